// File: rtl/snn_image_loader.sv
// Streams packed image bytes into a 1-bit-per-pixel input RAM, kicks the SNN
// core once a full frame is written, and sends the classified digit as ASCII.
module snn_image_loader #(
  parameter int         NUM_BYTES  = 98,
  parameter logic [7:0] ASCII_BASE = 8'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [9:0] ram_addr,
  output logic       ram_data,
  output logic       ram_we,
  output logic       snn_start,
  input  logic       snn_done,
  input  logic [3:0] snn_digit,
  input  logic       tx_rdy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [3:0] result,
  output logic       drop
);

  localparam int                BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;

  logic [2:0]        state;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [7:0]        tx_data_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_cnt  <= '0;
      result    <= 4'h0;
      tx_data_q <= 8'h00;
    end else begin
      case (state)
        S_LOAD: begin
          if (rx_rdy) begin
            shift_reg <= rx_data;
            bit_cnt   <= 3'd0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= S_START;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        S_START: begin
          byte_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (snn_done) begin
            result <= snn_digit;
            state  <= S_TX;
          end
        end
        S_TX: begin
          if (tx_rdy) begin
            tx_data_q <= ASCII_BASE + {4'h0, result};
            state     <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Pixel index is byte_cnt*8 + bit_cnt, i.e. a plain concatenation.
  assign ram_we    = (state == S_SHIFT);
  assign ram_addr  = 10'({byte_cnt, bit_cnt});
  assign ram_data  = shift_reg[bit_cnt];
  assign snn_start = (state == S_START);

  // The byte is driven live on the launch cycle and then held from the register
  // until the next launch, so it never moves when result is recaptured.
  assign tx_start = (state == S_TX) && tx_rdy;
  assign tx_data  = tx_start ? (ASCII_BASE + {4'h0, result}) : tx_data_q;

  assign drop = rx_rdy && (state != S_LOAD);

endmodule
